collision_scanner: RTL and testbench

Parametrised per-frame collision engine for the player sprite against a table of up to N_TILES terrain tiles. On a start pulse it latches the player position and walks the tile table through a synchronous-read port. It ORs per-side contact results across all enabled tiles and reports four side flags, plus the index and y of the first tile contacted on the player's down side (used for landing snap). It sits between the tile ROM/RAM and the player motion controller and runs once per frame.

---
 rtl/collision_scanner.sv | 162 ++++++++++++++++
 tb/tb_collision_scanner.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_scanner.sv
// Per-frame collision engine: walks a synchronous-read tile table and ORs
// per-side contact tests of the player box against every enabled tile.
module collision_scanner #(
  parameter int N_TILES = 32,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int PW      = 47,
  parameter int PH      = 41,
  parameter int TW      = 25,
  parameter int TH      = 24,
  parameter int HIN     = 10,
  parameter int VIN     = 5,
  parameter int TOL     = 3,
  localparam int AW     = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x_blue,
  input  logic [YW-1:0] y_blue,
  output logic [AW-1:0] tile_addr,
  input  logic [XW-1:0] tile_x,
  input  logic [YW-1:0] tile_y,
  input  logic          tile_en,
  output logic          busy,
  output logic          done,
  output logic [3:0]    is_Collision,
  output logic          down_valid,
  output logic [AW-1:0] down_idx,
  output logic [YW-1:0] down_y
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef logic [XW:0] xs_t;
  typedef logic [YW:0] ys_t;

  localparam logic [AW-1:0] LAST = AW'(N_TILES - 1);

  state_t        state, state_nxt;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          data_valid;
  logic [AW-1:0] eval_idx;
  logic          accept, fold, last;

  logic [3:0]    acc, acc_nxt;
  logic          acc_dv, acc_dv_nxt;
  logic [AW-1:0] acc_di, acc_di_nxt;
  logic [YW-1:0] acc_dy, acc_dy_nxt;

  function automatic xs_t sub_x(input xs_t a, input xs_t b);
    return (a >= b) ? a - b : '0;
  endfunction

  function automatic ys_t sub_y(input ys_t a, input ys_t b);
    return (a >= b) ? a - b : '0;
  endfunction

  // One bit wider than the coordinates so edge sums never wrap.
  xs_t px_e, tx_e, p_r, t_r;
  ys_t py_e, ty_e, p_b, t_b;
  logic x_ok, y_ok;
  logic [3:0] hit;

  assign px_e = xs_t'(px);
  assign tx_e = xs_t'(tile_x);
  assign py_e = ys_t'(py);
  assign ty_e = ys_t'(tile_y);
  assign p_r  = px_e + xs_t'(PW);
  assign t_r  = tx_e + xs_t'(TW);
  assign p_b  = py_e + ys_t'(PH);
  assign t_b  = ty_e + ys_t'(TH);

  assign x_ok = (sub_x(p_r, xs_t'(HIN)) >= tx_e) && (px_e + xs_t'(HIN) <= t_r);
  assign y_ok = (sub_y(p_b, ys_t'(VIN)) >= ty_e) && (py_e <= sub_y(t_b, ys_t'(1)));

  assign hit[0] = x_ok && (ty_e <= p_b) && (p_b <= ty_e + ys_t'(TOL));
  assign hit[1] = x_ok && (sub_y(t_b, ys_t'(TOL)) <= py_e) && (py_e <= t_b);
  assign hit[2] = y_ok && (tx_e <= p_r) && (p_r <= tx_e + xs_t'(TOL));
  assign hit[3] = y_ok && (sub_x(t_r, xs_t'(TOL)) <= px_e) && (px_e <= t_r);

  assign accept = start && (state != SCAN);
  assign fold   = (state == SCAN) && data_valid;
  assign last   = fold && (eval_idx == LAST);
  assign busy   = (state == SCAN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_nxt    = acc;
    acc_dv_nxt = acc_dv;
    acc_di_nxt = acc_di;
    acc_dy_nxt = acc_dy;
    if (fold && tile_en) begin
      acc_nxt = acc | hit;
      if (hit[0] && !acc_dv) begin
        acc_dv_nxt = 1'b1;
        acc_di_nxt = eval_idx;
        acc_dy_nxt = tile_y;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px           <= '0;
      py           <= '0;
      tile_addr    <= '0;
      eval_idx     <= '0;
      data_valid   <= 1'b0;
      acc          <= '0;
      acc_dv       <= 1'b0;
      acc_di       <= '0;
      acc_dy       <= '0;
      is_Collision <= '0;
      down_valid   <= 1'b0;
      down_idx     <= '0;
      down_y       <= '0;
    end else if (accept) begin
      px         <= x_blue;
      py         <= y_blue;
      tile_addr  <= '0;
      eval_idx   <= '0;
      data_valid <= 1'b0;
      acc        <= '0;
      acc_dv     <= 1'b0;
      acc_di     <= '0;
      acc_dy     <= '0;
    end else if (state == SCAN) begin
      if (tile_addr != LAST) tile_addr <= tile_addr + AW'(1);
      eval_idx   <= tile_addr;
      data_valid <= 1'b1;
      acc        <= acc_nxt;
      acc_dv     <= acc_dv_nxt;
      acc_di     <= acc_di_nxt;
      acc_dy     <= acc_dy_nxt;
      if (last) begin
        is_Collision <= acc_nxt;
        down_valid   <= acc_dv_nxt;
        down_idx     <= acc_di_nxt;
        down_y       <= acc_dy_nxt;
      end
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed bench for collision_scanner with a synchronous-read tile table model.
module tb_collision_scanner;
  localparam int N  = 32;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] x_blue;
  logic [YW-1:0] y_blue;
  logic [AW-1:0] tile_addr;
  logic [XW-1:0] tile_x;
  logic [YW-1:0] tile_y;
  logic          tile_en;
  logic          busy, done, down_valid;
  logic [3:0]    is_Collision;
  logic [AW-1:0] down_idx;
  logic [YW-1:0] down_y;

  logic [XW-1:0] tbl_x  [N];
  logic [YW-1:0] tbl_y  [N];
  logic          tbl_en [N];

  int checks   = 0;
  int failures = 0;

  collision_scanner dut (
    .clk(clk), .rst(rst), .start(start), .x_blue(x_blue), .y_blue(y_blue),
    .tile_addr(tile_addr), .tile_x(tile_x), .tile_y(tile_y), .tile_en(tile_en),
    .busy(busy), .done(done), .is_Collision(is_Collision),
    .down_valid(down_valid), .down_idx(down_idx), .down_y(down_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tile_x  <= tbl_x[tile_addr];
    tile_y  <= tbl_y[tile_addr];
    tile_en <= tbl_en[tile_addr];
  end

  task automatic clear_table();
    for (int i = 0; i < N; i++) begin
      tbl_x[i] = '0; tbl_y[i] = '0; tbl_en[i] = 1'b0;
    end
  endtask

  task automatic set_tile(input int i, input int x, input int y, input bit en);
    tbl_x[i] = XW'(x); tbl_y[i] = YW'(y); tbl_en[i] = en;
  endtask

  task automatic pulse_start(input int x, input int y);
    @(negedge clk);
    x_blue = XW'(x); y_blue = YW'(y); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Cycles counted from the edge that sampled start; -1 on timeout.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done) return;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x_blue = '0; y_blue = '0;
    clear_table();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, is_Collision, down_valid, down_idx, down_y, tile_addr} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b col=%b dv=%b idx=%0d y=%0d addr=%0d, want all 0",
               busy, done, is_Collision, down_valid, down_idx, down_y, tile_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_down();
    int lat;
    clear_table();
    set_tile(0, 110, 141, 1);
    pulse_start(100, 100);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b want 1", busy); end
    wait_done(lat);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL single_latency: got %0d want 33", lat); end
    checks++;
    if (is_Collision !== 4'b0001) begin failures++; $display("FAIL single_col: got %b want 0001", is_Collision); end
    checks++;
    if (down_valid !== 1'b1 || down_idx !== 5'd0 || down_y !== 9'd141) begin
      failures++;
      $display("FAIL single_down: got dv=%b idx=%0d y=%0d want dv=1 idx=0 y=141", down_valid, down_idx, down_y);
    end
    checks++;
    if (busy !== 1'b0 || tile_addr !== 5'd31) begin
      failures++;
      $display("FAIL single_done_state: got busy=%b addr=%0d want busy=0 addr=31", busy, tile_addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || is_Collision !== 4'b0001) begin
      failures++;
      $display("FAIL single_hold: got done=%b col=%b want done=0 col=0001", done, is_Collision);
    end
  endtask

  task automatic load_all_sides();
    clear_table();
    set_tile(3, 100, 76, 1);
    set_tile(5, 147, 100, 1);
    set_tile(7, 75, 100, 1);
    set_tile(9, 110, 141, 1);
    set_tile(12, 110, 142, 1);
  endtask

  task automatic test_all_sides();
    int lat;
    load_all_sides();
    pulse_start(100, 100);
    wait_done(lat);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL sides_latency: got %0d want 33", lat); end
    checks++;
    if (is_Collision !== 4'b1111) begin failures++; $display("FAIL sides_col: got %b want 1111", is_Collision); end
    checks++;
    if (down_valid !== 1'b1 || down_idx !== 5'd9 || down_y !== 9'd141) begin
      failures++;
      $display("FAIL sides_down: got dv=%b idx=%0d y=%0d want dv=1 idx=9 y=141", down_valid, down_idx, down_y);
    end
  endtask

  task automatic test_disabled();
    int lat;
    clear_table();
    set_tile(4, 110, 141, 0);
    pulse_start(100, 100);
    wait_done(lat);
    checks++;
    if (lat !== 33 || is_Collision !== 4'b0000) begin
      failures++;
      $display("FAIL disabled_col: got lat=%0d col=%b want lat=33 col=0000", lat, is_Collision);
    end
    checks++;
    if (down_valid !== 1'b0 || down_idx !== 5'd0 || down_y !== 9'd0) begin
      failures++;
      $display("FAIL disabled_down: got dv=%b idx=%0d y=%0d want 0 0 0", down_valid, down_idx, down_y);
    end
  endtask

  task automatic test_no_wrap();
    int lat;
    clear_table();
    set_tile(0, 110, 495, 1);
    pulse_start(100, 5);
    wait_done(lat);
    checks++;
    if (lat !== 33 || is_Collision !== 4'b0000 || down_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_wrap: got lat=%0d col=%b dv=%b want lat=33 col=0000 dv=0", lat, is_Collision, down_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    bit seen;
    load_all_sides();
    pulse_start(100, 100);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, is_Collision, down_valid, down_idx, down_y, tile_addr} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got busy=%b done=%b col=%b dv=%b idx=%0d y=%0d addr=%0d, want all 0",
               busy, done, is_Collision, down_valid, down_idx, down_y, tile_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL midreset_abort: got activity=%b want 0", seen); end
    pulse_start(100, 100);
    wait_done(lat);
    checks++;
    if (lat !== 33 || is_Collision !== 4'b1111 || down_idx !== 5'd9) begin
      failures++;
      $display("FAIL midreset_rescan: got lat=%0d col=%b idx=%0d want lat=33 col=1111 idx=9",
               lat, is_Collision, down_idx);
    end
  endtask

  task automatic test_back_to_back();
    int lat, extra;
    clear_table();
    set_tile(0, 110, 141, 1);
    pulse_start(300, 300);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 3) begin x_blue = 10'd100; y_blue = 9'd100; start = 1'b1; end
      if (c == 4) start = 1'b0;
      if (done) begin lat = c; break; end
    end
    checks++;
    if (lat !== 33 || is_Collision !== 4'b0000 || down_valid !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_ignored: got lat=%0d col=%b dv=%b want lat=33 col=0000 dv=0",
               lat, is_Collision, down_valid);
    end
    x_blue = 10'd100; y_blue = 9'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++;
    if (is_Collision !== 4'b0001 || down_valid !== 1'b1 || down_y !== 9'd141) begin
      failures++;
      $display("FAIL b2b_result: got col=%b dv=%b y=%0d want col=0001 dv=1 y=141",
               is_Collision, down_valid, down_y);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL b2b_single_done: got %0d extra done pulses want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_single_down();
    test_all_sides();
    test_disabled();
    test_no_wrap();
    test_reset_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
